// File: rtl/div_engine_pkg.sv
// Shared divider defines: FSM states, handshake levels, bus widths.
package div_engine_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_engine_step.sv
// div_step: one radix-2 restoring iteration over the 65-bit working register.
module div_step
  import div_engine_pkg::*;
(
  input  logic [64:0]       w,
  input  logic [RegBus-1:0] divisor,
  output logic [64:0]       w_next
);

  logic [32:0] m;

  always_comb begin
    m = {1'b0, w[63:32]} - {1'b0, divisor};
    if (m[32]) w_next = {w[63:0], 1'b0};
    else       w_next = {m[31:0], w[31:0], 1'b1};
  end

endmodule

// File: rtl/div_engine.sv
// div_engine: 32-cycle DIV/DIVU unit for EX; HI=remainder, LO=quotient.
// Define DIV_BYZERO_FAST_EN to finish a zero-divisor request early with 0.
module div_engine
  import div_engine_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e        state;
  logic [5:0]        cnt;
  logic [64:0]       w;
  logic [64:0]       w_next;
  logic [RegBus-1:0] divisor;
  logic              neg1;
  logic              neg2;
  logic [RegBus-1:0] op1_mag;
  logic [RegBus-1:0] op2_mag;
  logic [RegBus-1:0] q_fix;
  logic [RegBus-1:0] r_fix;

  div_step u_step (
    .w      (w),
    .divisor(divisor),
    .w_next (w_next)
  );

  always_comb begin
    op1_mag = opdata1_i;
    op2_mag = opdata2_i;
    if (signed_div_i && opdata1_i[31]) op1_mag = 32'd0 - opdata1_i;
    if (signed_div_i && opdata2_i[31]) op2_mag = 32'd0 - opdata2_i;
    // neg flags are only set for signed requests
    q_fix = (neg1 ^ neg2) ? 32'd0 - w[31:0] : w[31:0];
    r_fix = neg1 ? 32'd0 - w[64:33] : w[64:33];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      w        <= '0;
      divisor  <= '0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else if (annul_i) begin
      state    <= DivFree;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      unique case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart) begin
            cnt     <= '0;
            w       <= {32'd0, op1_mag, 1'b0};
            divisor <= op2_mag;
            neg1    <= signed_div_i & opdata1_i[31];
            neg2    <= signed_div_i & opdata2_i[31];
`ifdef DIV_BYZERO_FAST_EN
            state   <= (opdata2_i == '0) ? DivByZero : DivOn;
`else
            state   <= DivOn;
`endif
          end
        end
        DivByZero: begin
          w     <= '0;
          cnt   <= 6'd32;
          state <= DivOn;
        end
        DivOn: begin
          if (cnt == 6'd32) begin
            result_o <= {r_fix, q_fix};
            ready_o  <= DivResultReady;
            state    <= DivEnd;
          end else begin
            w   <= w_next;
            cnt <= cnt + 6'd1;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_engine.sv
// Scoreboard bench for div_engine.
module tb_div_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  div_engine dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 0) begin
      if (sg && a[31]) return {a, 32'h00000001};
      return {a, 32'hFFFFFFFF};
    end
    if (!sg) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  task automatic do_div(input string tag, input bit sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int lat, input int hold);
    int n;
    logic [63:0] e;
    logic [63:0] held;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb_q.push_back(exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      // operand changes after capture must be ignored
      if (n == 3) begin
        opdata1_i = ~a;
        opdata2_i = b + 32'd5;
      end
    end while (!ready_o && n < 100);
    if (!ready_o) begin
      check({tag, "_timeout"}, 64'(n), 64'(lat + 1));
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check({tag, "_res"}, result_o, e);
      check({tag, "_lat"}, 64'(n - 1), 64'(lat));
      held = result_o;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_res"}, result_o, held);
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_drop"}, 64'(ready_o), 64'd0);
    check({tag, "_res_clr"}, result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    bit          saw;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rdy", 64'(ready_o), 64'd0);
    check("reset_res", result_o, 64'd0);
    rst = 1'b0;

    do_div("u100_7", 0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);
    do_div("s_m7_2", 1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    do_div("s_ovf", 1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
    do_div("u_max", 0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, 0);
`ifdef DIV_BYZERO_FAST_EN
    do_div("u_dz", 0, 32'h1234, 32'd0, 64'd0, 2, 0);
    do_div("s_dz", 1, 32'hFFFFFF00, 32'd0, 64'd0, 2, 0);
`else
    do_div("u_dz", 0, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF, 33, 0);
    do_div("s_dz", 1, 32'hFFFFFF00, 32'd0, 64'hFFFFFF00_00000001, 33, 0);
`endif

    // annul at E10
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd500;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    saw     = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) saw = 1'b1;
      @(negedge clk);
    end
    check("annul_no_rdy", 64'(saw), 64'd0);
    do_div("u9_3", 0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    do_div("hold5", 0, 32'd1000, 32'd33, 64'h0000000A_0000001E, 33, 5);

    // rst mid-DivOn
    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    repeat (15) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("rst_mid_rdy", 64'(ready_o), 64'd0);
    check("rst_mid_res", result_o, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_idle", 64'(ready_o), 64'd0);
    do_div("after_rst", 1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, 0);

    for (int k = 0; k < 8; k++) begin
      rs = k[0];
      ra = $urandom;
      rb = $urandom_range(1, 32'h0000FFFF);
      if (k >= 6) rb = $urandom | 32'h1;
      do_div($sformatf("rnd%0d", k), rs, ra, rb, model(rs, ra, rb), 33, 0);
    end

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_engine.md
# div_engine

Multi-cycle 32-bit integer divider serving the EX stage's DIV/DIVU requests. It answers EX's start/operand/sign request with a 64-bit {remainder, quotient} result and a ready flag. EX stalls the pipeline until ready and writes the result into HI/LO. It uses radix-2 restoring division: one quotient bit per cycle, 32 iterations, with sign correction for signed operations.

## Interface
- No parameters; widths fixed at 32/64 bits.
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend; held stable by EX while start_i high
- opdata2_i  in  32  divisor; held stable by EX while start_i high
- start_i  in  1  DivStart(1)/DivStop(0) request level
- annul_i  in  1  flush: abandon current operation
- result_o  out  64  [63:32] remainder → HI, [31:0] quotient → LO
- ready_o  out  1  DivResultReady(1)/DivResultNotReady(0)

## Operation
- States: DivFree, DivByZero, DivOn, DivEnd; registered outputs.
- DivFree:
  - start_i=1 and annul_i=0: capture operands.
  - If signed_div_i=1, negate any negative operand to its magnitude.
  - Go to DivOn with cnt=0, or to DivByZero if the divisor is 0 (only with DIV_BYZERO_FAST_EN).
  - Otherwise stay in DivFree with ready_o=0 and result_o=0.
- DivByZero: load working register with 0 and go to DivOn with cnt=32, so the next edge finishes.
- DivOn, cnt<32, iteration step:
  - 65-bit working register w; w[63:32] is the partial remainder and w[31:0] shifts in quotient bits.
  - Compute m = {1'b0,w[63:32]} − {1'b0,divisor} (33-bit).
  - If m[32]=1: w ← {w[63:0],1'b0}; else: w ← {m[31:0],w[31:0],1'b1}.
  - cnt++.
- DivOn, cnt=32, finish:
  - Quotient q = w[31:0]; remainder r = w[64:33].
  - If signed and sign(dividend) ≠ sign(divisor): q ← −q.
  - If signed and dividend negative: r ← −r.
  - result_o ← {r,q}; ready_o ← 1; go to DivEnd.
- DivEnd:
  - Hold ready_o=1 and result_o stable while start_i=1.
  - On start_i=0: go to DivFree, ready_o←0, result_o←0.
- annul_i=1 in any state: next edge → DivFree, ready_o=0, result_o=0. annul_i has priority over start_i.
- Signed overflow case 0x80000000 / −1: quotient 0x80000000, remainder 0. Handled naturally by the 33-bit magnitude path.
- Operand changes after capture are ignored until the block returns to DivFree.

## Timing
- Reset: state=DivFree, cnt=0, w=0, ready_o=0, result_o=0.
- Latency: edge E0 samples start_i=1 in DivFree; the iteration step runs at edges E1..E32; ready_o and result_o become valid after edge E33.
- Divide by zero with macro: ready_o valid after E2.
- Handshake: EX drops start_i in the cycle it sees ready_o=1, so ready_o is high for exactly one cycle in normal use. EX writes HI/LO in that cycle.
- Back-to-back: a new start_i may be accepted one cycle after DivEnd → DivFree, i.e. no earlier than the cycle following ready deassertion.
- rst mid-operation: same as annul, plus cnt and w cleared.

## Configuration
- DIV_BYZERO_FAST_EN defined:
  - Divisor 0 → DivByZero; result_o=0, ready after E2.
- Not defined: no DivByZero state; a zero divisor runs the full 32 iterations.
  - Unsigned result: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed result: sign correction applies, giving quotient 0x00000001 for negative dividends (else 0xFFFFFFFF) and remainder = dividend.

## Structure
- Shared defines file (alongside AluOp/AluSel constants):
  - State encodings: DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - DoubleRegBus.
- One natural sub-module, div_step: combinational single iteration, (w, divisor) → w_next. It keeps the FSM file to control plus sign handling.

## Test plan
- Unsigned 100 / 7, start held until ready → ready after E33, result_o=0x00000002_0000000E; ready drops one edge after start_i=0.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000; unsigned 0xFFFFFFFF / 0x10 → 0x0000000F_0FFFFFFF.
- Divisor 0, unsigned dividend 0x1234 → with macro: ready after E2, result 0. Without macro: ready after E33, result 0x00001234_FFFFFFFF.
- annul_i pulse at E10 of an operation → ready_o never rises. A following 9 / 3 yields 0x00000000_00000003 after its own E33.
- start_i held high 5 cycles past ready → ready_o and result_o stable for all 5 cycles; rst asserted mid-DivOn → all outputs 0 next edge.
